// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with stall/flush and the registered store-data forwarding
// select (ForwardE) for the memory stage's write-data mux.
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] ex_rd,
  input  logic [1:0]    ex_m_signal,
  input  logic [1:0]    ex_wb_signal,
  output logic          valid,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] write_data,
  output logic [1:0]    m_signal,
  output logic [1:0]    wb_signal,
  output logic [RW-1:0] rd,
  output logic [1:0]    ForwardE
);

  localparam logic [1:0] FWD_OWN  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_RAMQ = 2'b10;

  logic          valid_r;
  logic [DW-1:0] alu_result_r;
  logic [DW-1:0] write_data_r;
  logic [1:0]    m_signal_r;
  logic [1:0]    wb_signal_r;
  logic [RW-1:0] rd_r;
  logic [1:0]    fwd_r;

  logic          hit_s;
  logic [1:0]    fwd_next_s;
  logic [1:0]    m_gated_s;
  logic [1:0]    wb_gated_s;

  // A store in EX reads the register the real MEM occupant is about to write (r0 excluded).
  function automatic logic store_hazard(
    input logic          occ_valid,
    input logic          occ_regwrite,
    input logic [RW-1:0] occ_rd,
    input logic [RW-1:0] src_rt,
    input logic          src_valid,
    input logic          src_wren
  );
    return occ_valid & occ_regwrite & (occ_rd != {RW{1'b0}}) & (occ_rd == src_rt)
           & src_valid & src_wren;
  endfunction

  // Forwarding select and bubble gating for the value captured on advance.
  always_comb begin
    hit_s      = store_hazard(valid_r, wb_signal_r[1], rd_r, ex_rt, ex_valid, ex_m_signal[0]);
    fwd_next_s = FWD_OWN;
    if (hit_s) begin
      if (m_signal_r[1]) begin
        fwd_next_s = FWD_RAMQ;
      end else begin
        fwd_next_s = FWD_WB;
      end
    end else begin
      fwd_next_s = FWD_OWN;
    end
    if (ex_valid) begin
      m_gated_s  = ex_m_signal;
      wb_gated_s = ex_wb_signal;
    end else begin
      m_gated_s  = 2'b00;
      wb_gated_s = 2'b00;
    end
  end

  // Stage registers: reset, then flush > stall > advance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_r      <= 1'b0;
      alu_result_r <= {DW{1'b0}};
      write_data_r <= {DW{1'b0}};
      m_signal_r   <= 2'b00;
      wb_signal_r  <= 2'b00;
      rd_r         <= {RW{1'b0}};
      fwd_r        <= FWD_OWN;
    end else if (flush) begin
      valid_r      <= 1'b0;
      alu_result_r <= {DW{1'b0}};
      write_data_r <= {DW{1'b0}};
      m_signal_r   <= 2'b00;
      wb_signal_r  <= 2'b00;
      rd_r         <= {RW{1'b0}};
      fwd_r        <= FWD_OWN;
    end else if (stall) begin
      valid_r      <= valid_r;
      alu_result_r <= alu_result_r;
      write_data_r <= write_data_r;
      m_signal_r   <= m_signal_r;
      wb_signal_r  <= wb_signal_r;
      rd_r         <= rd_r;
      fwd_r        <= fwd_r;
    end else begin
      valid_r      <= ex_valid;
      alu_result_r <= ex_alu_result;
      write_data_r <= ex_store_data;
      m_signal_r   <= m_gated_s;
      wb_signal_r  <= wb_gated_s;
      rd_r         <= ex_rd;
      fwd_r        <= fwd_next_s;
    end
  end

  assign valid      = valid_r;
  assign alu_result = alu_result_r;
  assign write_data = write_data_r;
  assign m_signal   = m_signal_r;
  assign wb_signal  = wb_signal_r;
  assign rd         = rd_r;
  assign ForwardE   = fwd_r;

endmodule
